// File: rtl/pc_counter_pkg.sv
// Shared definitions for the Hack CPU program counter: default width,
// reset value and the control-priority select encoding used by the
// next-state mux.
package pc_counter_pkg;

  localparam int PC_WIDTH       = 16;
  localparam int PC_RESET_VALUE = 0;

  // Next-state source, in priority order.
  typedef enum logic [1:0] {
    SEL_CLEAR = 2'd0,
    SEL_LOAD  = 2'd1,
    SEL_INC   = 2'd2,
    SEL_HOLD  = 2'd3
  } sel_t;

  // First match wins: clear, then load, then inc, else hold.
  function automatic sel_t pick_sel(input logic clear, input logic load,
                                    input logic inc);
    if (clear)     return SEL_CLEAR;
    else if (load) return SEL_LOAD;
    else if (inc)  return SEL_INC;
    else           return SEL_HOLD;
  endfunction

endpackage

// File: rtl/pc_counter_if.sv
// Control/data bundle between the CPU control path and the program counter.
// master drives the controls and jump target, slave returns the PC and wrap.
interface pc_counter_if #(
  parameter int WIDTH = 16
);

  logic             clear;
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             wrap;

  modport master (
    output clear, load, inc, in,
    input  out, wrap
  );

  modport slave (
    input  clear, load, inc, in,
    output out, wrap
  );

endinterface

// File: rtl/pc_counter_gates.sv
// Two-input primitive gates from the gate layer used by the incrementer.

module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/pc_counter_inc_chain.sv
// inc_chain: WIDTH-bit ripple incrementer built from half adders.
// Carry-in is tied to 1, so out = in + 1 mod 2^WIDTH and carry_out is set
// only when in is all-ones. Kept standalone so the ALU increment path can
// reuse it.
module inc_chain #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  // One half adder per bit: sum from xor_gate, carry from and_gate.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    xor_gate u_sum (
      .a (in[i]),
      .b (carry[i]),
      .y (out[i])
    );
    and_gate u_carry (
      .a (in[i]),
      .b (carry[i]),
      .y (carry[i+1])
    );
  end

  assign carry_out = carry[WIDTH];

endmodule

// File: rtl/pc_counter.sv
// pc_counter: Hack CPU program counter. Each rising edge it clears, loads a
// jump target, increments or holds (in that priority). out and wrap come
// straight from registers, so there is no combinational input-to-output path.
//
// Build option PC_COUNTER_STICKY_WRAP_EN: when defined, wrap latches on the
// first overflow and stays set until clear or rst_n; load leaves it alone.
// When undefined, wrap is a one-cycle pulse following an overflowing inc.
module pc_counter
  import pc_counter_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_counter_if.slave   bus
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_one;
  logic             carry;
  logic             wrap_q;
  sel_t             sel;

  inc_chain #(
    .WIDTH (WIDTH)
  ) u_inc (
    .in        (pc),
    .out       (pc_plus_one),
    .carry_out (carry)
  );

  assign sel = pick_sel(bus.clear, bus.load, bus.inc);

  // State register: PC value plus the overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_VALUE;
      wrap_q <= 1'b0;
    end else begin
      unique case (sel)
        SEL_CLEAR: begin
          pc     <= RESET_VALUE;
          wrap_q <= 1'b0;
        end
        SEL_LOAD: begin
          pc     <= bus.in;
`ifdef PC_COUNTER_STICKY_WRAP_EN
          wrap_q <= wrap_q;
`else
          wrap_q <= 1'b0;
`endif
        end
        SEL_INC: begin
          pc     <= pc_plus_one;
`ifdef PC_COUNTER_STICKY_WRAP_EN
          wrap_q <= wrap_q | carry;
`else
          wrap_q <= carry;
`endif
        end
        SEL_HOLD: begin
          pc     <= pc;
`ifdef PC_COUNTER_STICKY_WRAP_EN
          wrap_q <= wrap_q;
`else
          wrap_q <= 1'b0;
`endif
        end
        default: begin
          pc     <= pc;
          wrap_q <= wrap_q;
        end
      endcase
    end
  end

  assign bus.out  = pc;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: directed reset/count/overflow/priority/
// hold cases, a randomized control phase and a full increment sweep, all
// compared against an arithmetic reference model.
module tb_pc_counter;

  localparam int W    = 16;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic rst_n;

  pc_counter_if #(.WIDTH(W)) bus ();

  pc_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int exp_out  = 0;
  bit exp_wrap = 1'b0;

`ifdef PC_COUNTER_STICKY_WRAP_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // Controls must be known whenever the counter is out of reset.
  always @(posedge clk) begin
    if (rst_n === 1'b1)
      assert (!$isunknown({bus.clear, bus.load, bus.inc}));
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Apply one cycle of controls, advance the model, check 1 time unit after the edge.
  task automatic step(input string tag, input bit c, input bit l, input bit i,
                      input logic [W-1:0] d);
    bus.clear = c;
    bus.load  = l;
    bus.inc   = i;
    bus.in    = d;
    @(posedge clk);
    if (c) begin
      exp_out  = 0;
      exp_wrap = 1'b0;
    end else if (l) begin
      exp_out  = int'(d);
      exp_wrap = STICKY ? exp_wrap : 1'b0;
    end else if (i) begin
      bit ovf;
      ovf      = (exp_out == MASK);
      exp_out  = (exp_out + 1) % (1 << W);
      exp_wrap = STICKY ? (exp_wrap | ovf) : ovf;
    end else begin
      exp_wrap = STICKY ? exp_wrap : 1'b0;
    end
    #1;
    check_val({tag, ".out"},  32'(bus.out),  32'(exp_out));
    check_val({tag, ".wrap"}, 32'(bus.wrap), 32'(exp_wrap));
  endtask

  initial begin
    logic [W-1:0] rnd_in;
    int r;

    rst_n     = 1'b0;
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    bus.inc   = 1'b0;
    bus.in    = '0;

    #2;
    check_val("reset.out",  32'(bus.out),  32'h0);
    check_val("reset.wrap", 32'(bus.wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reach 0x0123, then reset asynchronously between edges.
    step("pre_load", 0, 1, 0, 16'h0120);
    for (int k = 0; k < 3; k++) step("pre_inc", 0, 0, 1, '0);
    check_val("pre_reset.out", 32'(bus.out), 32'h0123);
    bus.inc = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_out  = 0;
    exp_wrap = 1'b0;
    check_val("async_reset.out",  32'(bus.out),  32'h0);
    check_val("async_reset.wrap", 32'(bus.wrap), 32'h0);
    @(posedge clk);
    #1;
    check_val("reset_held.out", 32'(bus.out), 32'h0);
    @(negedge clk);
    bus.inc = 1'b0;
    rst_n   = 1'b1;
    for (int k = 0; k < 3; k++) step("post_reset_idle", 0, 0, 0, '0);

    // Counting from zero.
    for (int k = 1; k <= 5; k++) begin
      step("count", 0, 0, 1, '0);
      check_val("count.value", 32'(bus.out), 32'(k));
    end

    // Overflow.
    step("ovf_load", 0, 1, 0, 16'hFFFE);
    step("ovf_inc1", 0, 0, 1, '0);
    check_val("ovf_ffff", 32'(bus.out), 32'hFFFF);
    step("ovf_inc2", 0, 0, 1, '0);
    check_val("ovf_zero", 32'(bus.out), 32'h0);
    check_val("ovf_wrap", 32'(bus.wrap), 32'h1);
    step("ovf_after", 0, 0, 0, '0);

    // Priority.
    step("prio_load_inc", 0, 1, 1, 16'h1234);
    check_val("prio_load_inc.value", 32'(bus.out), 32'h1234);
    step("prio_all", 1, 1, 1, 16'h5555);
    check_val("prio_all.value", 32'(bus.out), 32'h0);

    // Hold.
    step("hold_load", 0, 1, 0, 16'h00A0);
    for (int k = 0; k < 10; k++) step("hold", 0, 0, 0, '0);

    // Randomized controls with corner-biased jump targets.
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       rnd_in = 16'hFFFF;
        1:       rnd_in = 16'hFFFE;
        default: rnd_in = W'($urandom);
      endcase
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), rnd_in);
    end

    // Increment sweep: every 16-bit value passes through a single inc.
    step("sweep_clear", 1, 0, 0, '0);
    for (int k = 0; k < (1 << W); k++) step("sweep", 0, 0, 1, '0);
    check_val("sweep_end", 32'(bus.out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
